lsu: RTL and testbench

Load/store unit for the memory stage of the RISC-V core. It accepts one memory operation per request from the pipeline and stalls the pipeline while the data-memory bus transaction is in flight. It aligns and sign/zero-extends load data and drives that result directly into the writeback result mux (`result_src` = 01 input). Stores are lane-steered with byte enables; misaligned, unsupported or timed-out accesses are reported without corrupting memory.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_if.sv | 22 ++
 rtl/lsu_load_align.sv | 32 +++
 rtl/lsu.sv | 127 ++++++++++++
 tb/tb_lsu.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and request legality check for the memory-stage load/store unit.
package lsu_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t F3_LB  = 3'b000;
  localparam funct3_t F3_LH  = 3'b001;
  localparam funct3_t F3_LW  = 3'b010;
  localparam funct3_t F3_LBU = 3'b100;
  localparam funct3_t F3_LHU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Unsigned byte stores do not exist; halfword/word accesses must be naturally aligned.
  function automatic logic req_illegal(input funct3_t f3, input logic write, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_LB:         bad = 1'b0;
      F3_LH, F3_LHU: bad = lo[0];
      F3_LW:         bad = (lo != 2'b00);
      F3_LBU:        bad = write;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the byte/halfword lane and extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  funct3_t     funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: one op per request, stalls the pipeline while the bus is busy.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  funct3_t               req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  lsu_if.master                 bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lat_write;
  funct3_t          lat_f3;
  logic [1:0]       lat_lo;
  logic             illegal;
  logic             accept;
  logic             timeout_hit;
  logic [31:0]      load_data;

  function automatic logic [31:0] store_lanes(input funct3_t f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input funct3_t f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  assign illegal     = req_illegal(req_funct3, req_write, req_addr[1:0]);
  assign accept      = (state == S_IDLE) && req_valid;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign stall       = accept || (state == S_BUS);

  lsu_load_align u_align (
    .mem_rdata (bus.mem_rdata),
    .addr_lo   (lat_lo),
    .funct3    (lat_f3),
    .load_data (load_data)
  );

  // Request fields needed after acceptance (load lane select, direction)
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_f3    <= req_funct3;
      lat_lo    <= req_addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state         <= S_BUS;
              cnt           <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= req_write;
              bus.mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.mem_wdata <= req_write ? store_lanes(req_funct3, req_wdata) : 32'd0;
              bus.mem_be    <= req_write ? store_be(req_funct3, req_addr[1:0]) : 4'b0000;
            end
          end
        end
        // Ack in the limit cycle takes priority over the timeout abort
        S_BUS: begin
          if (bus.mem_ack) begin
            if (!lat_write) rdata <= load_data;
            bus.mem_req <= 1'b0;
            state       <= S_RESP;
            done        <= 1'b1;
          end else if (timeout_hit) begin
            bus.mem_req <= 1'b0;
            state       <= S_RESP;
            done        <= 1'b1;
            err         <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: vector table replayed through a scoreboard plus reset/back-to-back sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall, done, err;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  lsu_if #(.ADDR_WIDTH(32)) bus ();

  lsu #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          ack_k;
    logic        use_bus;
    logic        e_err;
    int          done_c;
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    logic        e_err;
    logic [31:0] e_rdata;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_err"}, err, e.e_err);
      check({tag, "_rdata"}, rdata, e.e_rdata);
    end
  endtask

  task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] mr, input int k, input logic ub, input logic ee, input int dc,
                     input logic [31:0] er, input logic [3:0] be, input logic [31:0] ewd);
    vec_t v;
    v.write = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrdata = mr; v.ack_k = k;
    v.use_bus = ub; v.e_err = ee; v.done_c = dc; v.e_rdata = er; v.e_be = be; v.e_wdata = ewd;
    vecs.push_back(v);
  endtask

  task automatic all_zero(input string name);
    check(name, {stall, done, err, rdata, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}, 0);
  endtask

  task automatic run_op(input int idx, input vec_t v);
    string tag;
    logic  seen;
    tag  = $sformatf("v%0d", idx);
    seen = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = v.write; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    sb.push_back('{v.e_err, v.e_rdata});
    @(negedge clk);
    check({tag, "_stall_c0"}, stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    for (int c = 1; c <= 12 && !seen; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      bus.mem_ack   = (c == v.ack_k);
      bus.mem_rdata = (c == v.ack_k) ? v.mrdata : $urandom;
      @(negedge clk);
      if (c == 1 && v.use_bus) begin
        check({tag, "_mem_addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
        check({tag, "_mem_we"}, bus.mem_we, v.write);
        check({tag, "_mem_be"}, bus.mem_be, v.e_be);
        if (v.write) check({tag, "_mem_wdata"}, bus.mem_wdata, v.e_wdata);
      end
      if (done) begin
        seen = 1'b1;
        check({tag, "_done_cycle"}, c, v.done_c);
        check({tag, "_req_at_done"}, bus.mem_req, 0);
        check({tag, "_stall_at_done"}, stall, 0);
        sb_pop_check(tag);
      end else begin
        check({tag, "_mem_req"}, bus.mem_req, v.use_bus);
        check({tag, "_stall"}, stall, 1);
      end
    end
    bus.mem_ack = 1'b0;
    if (!seen) begin
      check({tag, "_done_missing"}, 0, 1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    //  w  f3      addr          wdata         mrdata        k  bus err dc rdata         be       wdata
    add(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 1, 0, 3, 32'hDEADBEEF, 4'b0000, 32'h0);
    add(0, 3'b000, 32'h103, 32'h0,        32'h80FF7F01, 1, 1, 0, 2, 32'hFFFFFF80, 4'b0000, 32'h0);
    add(0, 3'b100, 32'h103, 32'h0,        32'h80FF7F01, 1, 1, 0, 2, 32'h00000080, 4'b0000, 32'h0);
    add(0, 3'b001, 32'h102, 32'h0,        32'h80FF7F01, 1, 1, 0, 2, 32'hFFFF80FF, 4'b0000, 32'h0);
    add(0, 3'b101, 32'h102, 32'h0,        32'h80FF7F01, 1, 1, 0, 2, 32'h000080FF, 4'b0000, 32'h0);
    add(0, 3'b000, 32'h101, 32'h0,        32'h80FF7F01, 1, 1, 0, 2, 32'h0000007F, 4'b0000, 32'h0);
    add(0, 3'b001, 32'h100, 32'h0,        32'h80FF7F01, 1, 1, 0, 2, 32'h00007F01, 4'b0000, 32'h0);
    add(1, 3'b000, 32'h101, 32'h000000AB, 32'h55555555, 1, 1, 0, 2, 32'h00007F01, 4'b0010, 32'hABABABAB);
    add(1, 3'b001, 32'h102, 32'h1234ABCD, 32'h55555555, 2, 1, 0, 3, 32'h00007F01, 4'b1100, 32'hABCDABCD);
    add(1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h55555555, 1, 1, 0, 2, 32'h00007F01, 4'b1111, 32'hCAFEF00D);
    add(0, 3'b010, 32'h102, 32'h0,        32'h99999999, 1, 0, 1, 1, 32'h00007F01, 4'b0000, 32'h0);
    add(1, 3'b001, 32'h101, 32'h1234,     32'h99999999, 1, 0, 1, 1, 32'h00007F01, 4'b0000, 32'h0);
    add(0, 3'b011, 32'h100, 32'h0,        32'h99999999, 1, 0, 1, 1, 32'h00007F01, 4'b0000, 32'h0);
    add(1, 3'b100, 32'h100, 32'h0,        32'h99999999, 1, 0, 1, 1, 32'h00007F01, 4'b0000, 32'h0);
    add(0, 3'b110, 32'h100, 32'h0,        32'h99999999, 1, 0, 1, 1, 32'h00007F01, 4'b0000, 32'h0);
    add(0, 3'b111, 32'h100, 32'h0,        32'h99999999, 1, 0, 1, 1, 32'h00007F01, 4'b0000, 32'h0);
    add(0, 3'b001, 32'h101, 32'h0,        32'h99999999, 1, 0, 1, 1, 32'h00007F01, 4'b0000, 32'h0);
    add(0, 3'b010, 32'h101, 32'h0,        32'h99999999, 1, 0, 1, 1, 32'h00007F01, 4'b0000, 32'h0);
    add(0, 3'b010, 32'h200, 32'h0,        32'h77777777, 0, 1, 1, 5, 32'h00007F01, 4'b0000, 32'h0);
    add(0, 3'b010, 32'h204, 32'h0,        32'h0A0B0C0D, 4, 1, 0, 5, 32'h0A0B0C0D, 4'b0000, 32'h0);
    add(0, 3'b010, 32'h1FC, 32'h0,        32'h12345678, 3, 1, 0, 4, 32'h12345678, 4'b0000, 32'h0);
    add(0, 3'b101, 32'h1FE, 32'h0,        32'h89AB7654, 1, 1, 0, 2, 32'h000089AB, 4'b0000, 32'h0);
    add(0, 3'b000, 32'h102, 32'h0,        32'h89AB7654, 2, 1, 0, 3, 32'hFFFFFFAB, 4'b0000, 32'h0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    all_zero("reset_outputs");

    foreach (vecs[i]) run_op(i, vecs[i]);

    // Back-to-back loads with req_valid held; RESP must not accept the second one
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    sb.push_back('{1'b0, 32'h11112222});
    @(posedge clk); #1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11112222;
    @(negedge clk); check("b2b_req_c1", bus.mem_req, 1);
    @(posedge clk); #1; bus.mem_ack = 1'b0;
    @(negedge clk);
    check("b2b_done_c2", done, 1);
    check("b2b_stall_c2", stall, 0);
    sb_pop_check("b2b_first");
    sb.push_back('{1'b0, 32'h33334444});
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_done_c3", done, 0);
    check("b2b_req_c3", bus.mem_req, 0);
    check("b2b_stall_c3", stall, 1);
    @(posedge clk); #1; req_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h33334444;
    @(negedge clk); check("b2b_req_c4", bus.mem_req, 1);
    @(posedge clk); #1; bus.mem_ack = 1'b0;
    @(negedge clk);
    check("b2b_done_c5", done, 1);
    sb_pop_check("b2b_second");

    // Reset during BUS aborts the op without a done pulse
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); check("rst_mid_req_c1", bus.mem_req, 1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); all_zero("rst_mid_outputs");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid_quiet%0d", c), {done, bus.mem_req}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
